// File: rtl/case_1_mul_pkg.sv
`default_nettype none
// =============================================================================
// case_1_mul_pkg : shared constants and helpers for the case_1 pipelined multiplier
// Revision: 1.0
// =============================================================================
package case_1_mul_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic int full_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic logic [63:0] sat_max_s(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Only the low w bits are meaningful: a single 1 in the sign position.
    function automatic logic [63:0] sat_min_s(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] sat_max_u(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_1_mul_narrow.sv
`default_nettype none
// =============================================================================
// case_1_mul_narrow : combinational wrap/saturate narrowing of a full product
// Revision: 1.0
// =============================================================================
module case_1_mul_narrow
    import case_1_mul_pkg::*;
#(
    parameter int FULL_WIDTH = 20,
    parameter int dout_WIDTH = 10,
    parameter int SIGNED     = 1,
    parameter int SAT_MODE   = MODE_SAT
) (
    input  logic [FULL_WIDTH-1:0] prod,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    generate
        if (dout_WIDTH >= FULL_WIDTH) begin : g_full
            assign dout = prod;
            assign ovf  = 1'b0;
        end else begin : g_narrow
            logic lost;

            // Value changes iff the discarded bits are not a pure extension of the kept ones.
            if (SIGNED != 0) begin : g_lost_s
                logic [FULL_WIDTH-dout_WIDTH:0] top;
                assign top  = prod[FULL_WIDTH-1:dout_WIDTH-1];
                assign lost = ~((&top) | ~(|top));
            end else begin : g_lost_u
                assign lost = |prod[FULL_WIDTH-1:dout_WIDTH];
            end

            if (SAT_MODE == MODE_SAT) begin : g_sat
                if (SIGNED != 0) begin : g_sat_s
                    localparam logic [dout_WIDTH-1:0] C_MAX = dout_WIDTH'(sat_max_s(dout_WIDTH));
                    localparam logic [dout_WIDTH-1:0] C_MIN = dout_WIDTH'(sat_min_s(dout_WIDTH));
                    assign dout = lost ? (prod[FULL_WIDTH-1] ? C_MIN : C_MAX)
                                       : prod[dout_WIDTH-1:0];
                end else begin : g_sat_u
                    localparam logic [dout_WIDTH-1:0] C_MAX = dout_WIDTH'(sat_max_u(dout_WIDTH));
                    assign dout = lost ? C_MAX : prod[dout_WIDTH-1:0];
                end
            end else begin : g_wrap
                assign dout = prod[dout_WIDTH-1:0];
            end

            assign ovf = lost;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/case_1_mul_pipe_sat.sv
`default_nettype none
// =============================================================================
// case_1_mul_pipe_sat : pipelined multiplier, valid/ready with global stall, wrap/sat narrowing
// Revision: 1.0
// =============================================================================
module case_1_mul_pipe_sat
    import case_1_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 10,
    parameter int SIGNED     = 1,
    parameter int SAT_MODE   = MODE_SAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int FW = full_width(din0_WIDTH, din1_WIDTH);

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_depth
            $error("case_1_mul_pipe_sat: NUM_STAGE out of range 1..8");
        end
        if (dout_WIDTH < 2 || dout_WIDTH > FW) begin : g_bad_width
            $error("case_1_mul_pipe_sat: dout_WIDTH out of range");
        end
        if (ID < 0) begin : g_bad_id
            $error("case_1_mul_pipe_sat: ID must be non-negative");
        end
    endgenerate

    logic          adv;
    logic [FW-1:0] prod;
    logic [dout_WIDTH-1:0] nar_dout;
    logic                  nar_ovf;

    logic                  vld [NUM_STAGE];
    logic [dout_WIDTH-1:0] dat [NUM_STAGE];
    logic                  ovr [NUM_STAGE];

    assign adv      = ce & (~out_valid | out_ready);
    assign in_ready = adv;

    generate
        if (SIGNED != 0) begin : g_mul_s
            logic signed [FW-1:0] a;
            logic signed [FW-1:0] b;
            assign a    = FW'($signed(din0));
            assign b    = FW'($signed(din1));
            assign prod = a * b;
        end else begin : g_mul_u
            assign prod = FW'(din0) * FW'(din1);
        end
    endgenerate

    // Narrowing happens before the first register so the stages carry only dout_WIDTH bits.
    case_1_mul_narrow #(
        .FULL_WIDTH (FW),
        .dout_WIDTH (dout_WIDTH),
        .SIGNED     (SIGNED),
        .SAT_MODE   (SAT_MODE)
    ) u_narrow (
        .prod (prod),
        .dout (nar_dout),
        .ovf  (nar_ovf)
    );

    generate
        for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
            logic                  v_in;
            logic [dout_WIDTH-1:0] d_in;
            logic                  o_in;

            if (i == 0) begin : g_head
                assign v_in = in_valid;
                assign d_in = nar_dout;
                assign o_in = nar_ovf;
            end else begin : g_body
                assign v_in = vld[i-1];
                assign d_in = dat[i-1];
                assign o_in = ovr[i-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld[i] <= 1'b0;
                    dat[i] <= '0;
                    ovr[i] <= 1'b0;
                end else if (adv) begin
                    vld[i] <= v_in;
                    dat[i] <= d_in;
                    ovr[i] <= o_in;
                end
            end
        end
    endgenerate

    assign out_valid = vld[NUM_STAGE-1];
    assign dout      = dat[NUM_STAGE-1];
    assign ovf       = ovr[NUM_STAGE-1];

endmodule
`default_nettype wire
